// File: rtl/seven_seg_pkg.sv
// Shared seven-segment constants for the encoder and capture sides.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package seven_seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Index is the hex value the pattern displays.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

endpackage

// File: rtl/seven_seg_pattern_decode.sv
// Combinational segment-pattern to hex decode.
// Non-hex patterns report legal=0 with nibble 0.
module seven_seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic       blank,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_HEX[i]) begin
        legal  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

  assign blank = (seg == SEG_BLANK);

endmodule

// File: rtl/seven_seg_capture_decoder.sv
// Captures a multiplexed seven-segment scan bus into a per-digit hex bank,
// committing each digit only after its pattern has been stable long enough.
module seven_seg_capture_decoder
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic [6:0]              i_SEVEN_SEG,
  input  logic [NUM_DIGITS-1:0]   i_DIGIT_SEL,
  output logic [4*NUM_DIGITS-1:0] o_BINARY,
  output logic [NUM_DIGITS-1:0]   o_DIGIT_VALID,
  output logic [NUM_DIGITS-1:0]   o_ILLEGAL,
  output logic                    o_UPDATE,
  output logic                    o_SEL_ERROR
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [NUM_DIGITS-1:0] s_sel;
  logic [6:0]            s_seg;
  logic [CW-1:0]         cnt;

  logic       same, multi_hot, one_hot, commit, change;
  logic       legal, blank;
  logic [3:0] nibble, cur_bin;
  logic       cur_vld;

  // Decode the sampled pattern; it equals the live input whenever commit fires.
  seven_seg_pattern_decode u_dec (
    .seg    (s_seg),
    .legal  (legal),
    .blank  (blank),
    .nibble (nibble)
  );

  assign same      = (i_DIGIT_SEL == s_sel) && (i_SEVEN_SEG == s_seg);
  assign multi_hot = ($countones(i_DIGIT_SEL) > 1);
  assign one_hot   = $onehot(i_DIGIT_SEL);
  assign commit    = same && one_hot && (cnt == CW'(STABLE_CYCLES - 1));

  always_comb begin
    cur_bin = 4'h0;
    cur_vld = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (s_sel[d]) begin
        cur_bin = o_BINARY[4*d +: 4];
        cur_vld = o_DIGIT_VALID[d];
      end
    end
  end

  // Illegal-flag transitions alone are not reported as an update.
  assign change = commit && (legal ? (!cur_vld || cur_bin != nibble) : cur_vld);

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      s_sel         <= '0;
      s_seg         <= '0;
      cnt           <= '0;
      o_BINARY      <= '0;
      o_DIGIT_VALID <= '0;
      o_ILLEGAL     <= '0;
      o_UPDATE      <= 1'b0;
      o_SEL_ERROR   <= 1'b0;
    end else begin
      s_sel       <= i_DIGIT_SEL;
      s_seg       <= i_SEVEN_SEG;
      o_UPDATE    <= change;
      // A held multi-hot select reports once, on its first sample.
      o_SEL_ERROR <= multi_hot && !same;

      if (multi_hot)
        cnt <= '0;
      else if (same) begin
        if (cnt != CW'(STABLE_CYCLES))
          cnt <= cnt + 1'b1;
      end else
        cnt <= CW'(1);

      if (commit) begin
        for (int d = 0; d < NUM_DIGITS; d++) begin
          if (s_sel[d]) begin
            if (legal) begin
              o_BINARY[4*d +: 4] <= nibble;
              o_DIGIT_VALID[d]   <= 1'b1;
              o_ILLEGAL[d]       <= 1'b0;
            end else begin
              o_DIGIT_VALID[d]   <= 1'b0;
              o_ILLEGAL[d]       <= !blank;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture_decoder.sv
// Directed bench for seven_seg_capture_decoder (4 digits, 8-cycle stability).
module tb_seven_seg_capture_decoder;

  logic        i_CLK = 1'b0;
  logic        i_RST = 1'b1;
  logic [6:0]  i_SEVEN_SEG = '0;
  logic [3:0]  i_DIGIT_SEL = '0;
  logic [15:0] o_BINARY;
  logic [3:0]  o_DIGIT_VALID;
  logic [3:0]  o_ILLEGAL;
  logic        o_UPDATE;
  logic        o_SEL_ERROR;

  int checks = 0;
  int errors = 0;
  int upd_pulses = 0;
  int sel_pulses = 0;

  seven_seg_capture_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
    .i_CLK         (i_CLK),
    .i_RST         (i_RST),
    .i_SEVEN_SEG   (i_SEVEN_SEG),
    .i_DIGIT_SEL   (i_DIGIT_SEL),
    .o_BINARY      (o_BINARY),
    .o_DIGIT_VALID (o_DIGIT_VALID),
    .o_ILLEGAL     (o_ILLEGAL),
    .o_UPDATE      (o_UPDATE),
    .o_SEL_ERROR   (o_SEL_ERROR)
  );

  always #5 i_CLK = ~i_CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic [3:0] sel, input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) begin
      i_DIGIT_SEL = sel;
      i_SEVEN_SEG = seg;
      @(posedge i_CLK);
      #1;
      upd_pulses += int'(o_UPDATE);
      sel_pulses += int'(o_SEL_ERROR);
    end
  endtask

  task automatic test_reset();
    i_RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_DIGIT_SEL = 4'($urandom);
      i_SEVEN_SEG = 7'($urandom);
      @(posedge i_CLK);
      #1;
    end
    checks++;
    if ({o_BINARY, o_DIGIT_VALID, o_ILLEGAL, o_UPDATE, o_SEL_ERROR} !== 26'h0) begin
      errors++;
      $display("FAIL reset_outputs: got bin=%h vld=%b ill=%b upd=%b selerr=%b, want all 0",
               o_BINARY, o_DIGIT_VALID, o_ILLEGAL, o_UPDATE, o_SEL_ERROR);
    end
    i_RST = 1'b0;
    upd_pulses = 0; sel_pulses = 0;
    step(4'b0000, 7'b0000000, 4);
    checks++;
    if (upd_pulses !== 0 || sel_pulses !== 0 || o_DIGIT_VALID !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: got upd=%0d selerr=%0d vld=%b, want 0 0 0000",
               upd_pulses, sel_pulses, o_DIGIT_VALID);
    end
  endtask

  task automatic test_single_digit();
    upd_pulses = 0;
    step(4'b0001, 7'b1011011, 7);
    checks++;
    if (o_DIGIT_VALID !== 4'b0000 || upd_pulses !== 0) begin
      errors++;
      $display("FAIL early_commit: got vld=%b upd=%0d after 7 edges, want 0000 0",
               o_DIGIT_VALID, upd_pulses);
    end
    step(4'b0001, 7'b1011011, 1);
    checks++;
    if (o_UPDATE !== 1'b1 || o_BINARY[3:0] !== 4'h2 || o_DIGIT_VALID !== 4'b0001) begin
      errors++;
      $display("FAIL commit_edge8: got upd=%b nib=%h vld=%b, want 1 2 0001",
               o_UPDATE, o_BINARY[3:0], o_DIGIT_VALID);
    end
    upd_pulses = 0;
    step(4'b0001, 7'b1011011, 20);
    checks++;
    if (upd_pulses !== 0) begin
      errors++;
      $display("FAIL no_recommit: got %0d update pulses, want 0", upd_pulses);
    end
  endtask

  task automatic test_scan();
    logic [6:0] pats [4];
    pats = '{7'b0000110, 7'b1011011, 7'b1001111, 7'b1110001};
    upd_pulses = 0;
    step(4'b0000, 7'b0000000, 2);
    for (int d = 0; d < 4; d++) begin
      step(4'(1 << d), pats[d], 10);
      step(4'b0000, 7'b0000000, 2);
    end
    checks++;
    if (o_BINARY !== 16'hF321 || o_DIGIT_VALID !== 4'b1111) begin
      errors++;
      $display("FAIL scan_bank: got bin=%h vld=%b, want f321 1111", o_BINARY, o_DIGIT_VALID);
    end
    checks++;
    if (upd_pulses !== 4) begin
      errors++;
      $display("FAIL scan_pulses: got %0d, want 4", upd_pulses);
    end
  endtask

  task automatic test_glitch();
    upd_pulses = 0;
    step(4'b0010, 7'b0000111, 5);
    step(4'b0010, 7'b1111111, 1);
    checks++;
    if (o_BINARY !== 16'hF321 || upd_pulses !== 0) begin
      errors++;
      $display("FAIL glitch_partial: got bin=%h upd=%0d, want f321 0", o_BINARY, upd_pulses);
    end
    step(4'b0010, 7'b0000111, 8);
    step(4'b0000, 7'b0000000, 2);
    checks++;
    if (o_BINARY !== 16'hF371 || o_DIGIT_VALID !== 4'b1111 || upd_pulses !== 1) begin
      errors++;
      $display("FAIL glitch_commit: got bin=%h vld=%b upd=%0d, want f371 1111 1",
               o_BINARY, o_DIGIT_VALID, upd_pulses);
    end
  endtask

  task automatic test_illegal_blank();
    upd_pulses = 0;
    step(4'b0100, 7'b1000000, 10);
    checks++;
    if (o_ILLEGAL !== 4'b0100 || o_DIGIT_VALID !== 4'b1011 || o_BINARY !== 16'hF371 ||
        upd_pulses !== 1) begin
      errors++;
      $display("FAIL illegal: got ill=%b vld=%b bin=%h upd=%0d, want 0100 1011 f371 1",
               o_ILLEGAL, o_DIGIT_VALID, o_BINARY, upd_pulses);
    end
    upd_pulses = 0;
    step(4'b0100, 7'b0000000, 10);
    checks++;
    if (o_ILLEGAL !== 4'b0000 || o_DIGIT_VALID !== 4'b1011 || o_BINARY !== 16'hF371 ||
        upd_pulses !== 0) begin
      errors++;
      $display("FAIL blank: got ill=%b vld=%b bin=%h upd=%0d, want 0000 1011 f371 0",
               o_ILLEGAL, o_DIGIT_VALID, o_BINARY, upd_pulses);
    end
  endtask

  task automatic test_multi_hot_reset();
    upd_pulses = 0; sel_pulses = 0;
    step(4'b0000, 7'b0000000, 2);
    step(4'b0101, 7'b1111111, 1);
    checks++;
    if (o_SEL_ERROR !== 1'b1) begin
      errors++;
      $display("FAIL sel_error_pulse: got %b, want 1", o_SEL_ERROR);
    end
    step(4'b0101, 7'b1111111, 11);
    checks++;
    if (sel_pulses !== 1 || upd_pulses !== 0 || o_BINARY !== 16'hF371 ||
        o_DIGIT_VALID !== 4'b1011) begin
      errors++;
      $display("FAIL multi_hot: got selerr=%0d upd=%0d bin=%h vld=%b, want 1 0 f371 1011",
               sel_pulses, upd_pulses, o_BINARY, o_DIGIT_VALID);
    end
    step(4'b0001, 7'b1111111, 4);
    i_RST = 1'b1;
    step(4'b0001, 7'b1111111, 1);
    checks++;
    if ({o_BINARY, o_DIGIT_VALID, o_ILLEGAL, o_UPDATE, o_SEL_ERROR} !== 26'h0) begin
      errors++;
      $display("FAIL mid_reset: got bin=%h vld=%b ill=%b, want all 0",
               o_BINARY, o_DIGIT_VALID, o_ILLEGAL);
    end
    i_RST = 1'b0;
    upd_pulses = 0;
    step(4'b0001, 7'b1111111, 3);
    step(4'b0000, 7'b0000000, 10);
    checks++;
    if (o_DIGIT_VALID !== 4'b0000 || o_BINARY !== 16'h0000 || upd_pulses !== 0) begin
      errors++;
      $display("FAIL post_reset_commit: got vld=%b bin=%h upd=%0d, want 0000 0000 0",
               o_DIGIT_VALID, o_BINARY, upd_pulses);
    end
  endtask

  task automatic test_back_to_back();
    upd_pulses = 0;
    step(4'b0010, 7'b0000110, 7);
    step(4'b0000, 7'b0000000, 3);
    checks++;
    if (o_DIGIT_VALID !== 4'b0000 || upd_pulses !== 0) begin
      errors++;
      $display("FAIL seven_cycle_hold: got vld=%b upd=%0d, want 0000 0", o_DIGIT_VALID, upd_pulses);
    end
    step(4'b1000, 7'b1101101, 8);
    step(4'b0001, 7'b1100111, 8);
    step(4'b0000, 7'b0000000, 2);
    checks++;
    if (o_BINARY !== 16'h5009 || o_DIGIT_VALID !== 4'b1001 || upd_pulses !== 2) begin
      errors++;
      $display("FAIL back_to_back: got bin=%h vld=%b upd=%0d, want 5009 1001 2",
               o_BINARY, o_DIGIT_VALID, upd_pulses);
    end
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_scan();
    test_glitch();
    test_illegal_blank();
    test_multi_hot_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
